// File: rtl/inst_prefetch.sv
// Instruction-fetch front end: request stream, DEPTH-entry instruction FIFO, valid/ready to decode.
// Optional static branch prediction on push when PREFETCH_BPRED_EN is defined.
module inst_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            inst_ce_o,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    input  logic            ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam int unsigned     AW  = $clog2(DEPTH);
    localparam int unsigned     CW  = AW + 1;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_infl_pc;
    logic            r_infl_v;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_inst_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem   [DEPTH];

    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_req;
    logic [CW-1:0]   w_occ;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ready_i;
    assign w_push  = r_infl_v;
    assign w_occ   = r_count + CW'(r_infl_v);
    // Credit check counts the in-flight response so a push can never overflow.
    assign w_req   = rst & ~redirect_i & ((w_occ < CW'(DEPTH)) | w_pop);

`ifdef PREFETCH_BPRED_EN
    logic [DEPTH-1:0] r_pred_mem;
    logic [6:0]       w_opc;
    logic             w_bp_hit;
    logic             w_bp_take;
    logic [XLEN-1:0]  w_bp_imm;
    logic [XLEN-1:0]  w_bp_target;

    assign w_opc = inst_i[6:0];

    always_comb begin
        w_bp_hit = 1'b0;
        w_bp_imm = '0;
        if (w_opc == 7'b1100011 && inst_i[31]) begin
            w_bp_hit = 1'b1;
            w_bp_imm = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        end else if (w_opc == 7'b1101111) begin
            w_bp_hit = 1'b1;
            w_bp_imm = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
    end

    assign w_bp_take   = w_push & w_bp_hit;
    assign w_bp_target = r_infl_pc + w_bp_imm;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_infl_pc  <= '0;
            r_infl_v   <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i;
            r_infl_v   <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_infl_v   <= 1'b1;
                r_infl_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end else begin
                r_infl_v   <= 1'b0;
            end
`ifdef PREFETCH_BPRED_EN
            // A predicted-taken push squashes the sequential request issued alongside it.
            if (w_bp_take) begin
                r_infl_v   <= 1'b0;
                r_fetch_pc <= w_bp_target;
            end
`endif
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !redirect_i) begin
            r_inst_mem[r_wr_ptr] <= inst_i;
            r_pc_mem[r_wr_ptr]   <= r_infl_pc;
`ifdef PREFETCH_BPRED_EN
            r_pred_mem[r_wr_ptr] <= w_bp_hit;
`endif
        end
    end

    assign inst_addr_o = r_fetch_pc;
    assign inst_ce_o   = w_req;
    assign valid_o     = w_valid;
    assign inst_o      = w_valid ? r_inst_mem[r_rd_ptr] : NOP;
    assign pc_o        = w_valid ? r_pc_mem[r_rd_ptr] : '0;
`ifdef PREFETCH_BPRED_EN
    assign pred_taken_o = w_valid & r_pred_mem[r_rd_ptr];
`else
    assign pred_taken_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: memory returns word=addr, with an optional beq planted at 0x20.
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_o;
    logic        inst_ce_o;
    logic [31:0] inst_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_req  = 0;
    int          base;
    logic        bp_mode;
    logic        found;
    logic [31:0] exp_next_pc;
    logic        exp_pred;

    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;

    inst_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_addr_o   (inst_addr_o),
        .inst_ce_o     (inst_ce_o),
        .inst_i        (inst_i),
        .valid_o       (valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .pred_taken_o  (pred_taken_o),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    // Memory: one-cycle latency, word equals address except the planted branch.
    always @(posedge clk) begin
        if (inst_ce_o) begin
            inst_i <= (bp_mode && inst_addr_o == 32'h20) ? BEQ_M16 : inst_addr_o;
            n_req  <= n_req + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; bp_mode = 1'b0;
        repeat (2) step();

        // Reset values
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_inst", inst_o, 32'h13);
        check_val("rst_pc", pc_o, 32'd0);
        check_val("rst_pred", 32'(pred_taken_o), 32'd0);
        check_val("rst_ce", 32'(inst_ce_o), 32'd0);

        // Sequential stream
        rst = 1'b1;
        #1;
        check_val("seq_ce1", 32'(inst_ce_o), 32'd1);
        check_val("seq_addr1", inst_addr_o, 32'd0);
        step();
        check_val("seq_valid_c1", 32'(valid_o), 32'd0);
        step();
        check_val("seq_valid_c2", 32'(valid_o), 32'd1);
        check_val("seq_pc0", pc_o, 32'd0);
        check_val("seq_inst0", inst_o, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_val("seq_valid", 32'(valid_o), 32'd1);
            check_val("seq_pc", pc_o, 32'(k * 4));
        end

        // Backpressure from reset
        rst = 1'b0; ready_i = 1'b0;
        #1;
        step();
        base = n_req;
        rst = 1'b1;
        repeat (8) step();
        check_val("bp_nreq", 32'(n_req - base), 32'd4);
        check_val("bp_ce_full", 32'(inst_ce_o), 32'd0);
        check_val("bp_valid", 32'(valid_o), 32'd1);
        check_val("bp_head", pc_o, 32'd0);
        ready_i = 1'b1;
        #1;
        check_val("bp_ce_resume", 32'(inst_ce_o), 32'd1);
        check_val("bp_addr_resume", inst_addr_o, 32'd16);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val("bp_drain_valid", 32'(valid_o), 32'd1);
            check_val("bp_drain_pc", pc_o, 32'(k * 4));
        end

        // Redirect with three entries buffered and one in flight
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        #1;
        check_val("rd_ce_forced0", 32'(inst_ce_o), 32'd0);
        step();
        redirect_i = 1'b0;
        #1;
        check_val("rd_valid_e1", 32'(valid_o), 32'd0);
        check_val("rd_addr", inst_addr_o, 32'h100);
        check_val("rd_ce", 32'(inst_ce_o), 32'd1);
        step();
        check_val("rd_drop", 32'(valid_o), 32'd0);
        step();
        check_val("rd_valid_e3", 32'(valid_o), 32'd1);
        check_val("rd_pc", pc_o, 32'h100);
        check_val("rd_inst", inst_o, 32'h100);

        // Address wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        #1;
        check_val("wrap_addr_top", inst_addr_o, 32'hFFFF_FFFC);
        step();
        check_val("wrap_addr_zero", inst_addr_o, 32'h0);
        step();
        check_val("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
        step();
        check_val("wrap_pc_zero", pc_o, 32'h0);

        // Backward beq at 0x20
`ifdef PREFETCH_BPRED_EN
        exp_next_pc = 32'h10; exp_pred = 1'b1;
`else
        exp_next_pc = 32'h24; exp_pred = 1'b0;
`endif
        bp_mode = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h18;
        step();
        redirect_i = 1'b0;
        step();
        step();
        check_val("br_pc18", pc_o, 32'h18);
        step();
        check_val("br_pc1c", pc_o, 32'h1C);
        step();
        check_val("br_pc20", pc_o, 32'h20);
        check_val("br_inst20", inst_o, BEQ_M16);
        check_val("br_pred", 32'(pred_taken_o), 32'(exp_pred));
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            step();
            if (valid_o && pc_o !== 32'h20) found = 1'b1;
        end
        check_val("br_found", 32'(found), 32'd1);
        check_val("br_next_pc", pc_o, exp_next_pc);
        bp_mode = 1'b0;

        // Asynchronous reset with two entries buffered
        ready_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        step();
        step();
        step();
        check_val("ar_valid_pre", 32'(valid_o), 32'd1);
        check_val("ar_pc_pre", pc_o, 32'h40);
        rst = 1'b0;
        #1;
        check_val("ar_valid", 32'(valid_o), 32'd0);
        check_val("ar_ce", 32'(inst_ce_o), 32'd0);
        check_val("ar_pc", pc_o, 32'd0);
        check_val("ar_inst", inst_o, 32'h13);
        #2;
        rst = 1'b1; ready_i = 1'b1;
        #1;
        check_val("ar_ce_rel", 32'(inst_ce_o), 32'd1);
        check_val("ar_addr_rel", inst_addr_o, 32'd0);
        step();
        step();
        check_val("ar_valid_rel", 32'(valid_o), 32'd1);
        check_val("ar_pc_rel", pc_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
